seq101_scan_ctrl: RTL
=====================

Name: seq101_scan_ctrl

Overview:
Controller that accepts a W-bit word over a start/busy handshake and feeds it MSB-first, one bit per enabled cycle, into an embedded overlapping "101" Mealy detector. It counts completed matches and records the bit positions where they occurred, then reports both with a one-cycle done pulse. Detector history can be cleared or carried across words, so a bit stream can be scanned in W-bit chunks.

Parameters:
W, 8, word width in bits; legal range 3..32
CW, $clog2(W+1), match-count width; derived, not overridden

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-low reset
start  input  1  request to scan word_in; honoured only in IDLE
word_in  input  W  word to scan; sampled on the accepting edge
clear_hist  input  1  sampled with start; 1 = detector state cleared before the first bit
hold  input  1  in SHIFT, 1 = no bit consumed this cycle
abort  input  1  in SHIFT, 1 = stop scan and return to IDLE
busy  output  1  1 in SHIFT and DONE
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse after an abort
match_cnt  output  CW  matches found in the current/last word
match_pos  output  W  bit i = 1 if a "101" completed on word bit i

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, detector state=S0; busy, done and aborted = 0; match_cnt and match_pos = 0. Reset overrides all inputs, including mid-scan.
- States: IDLE, SHIFT, DONE (2-bit encoding from the package).
- IDLE: start=1 → latch word_in, match_cnt=0, match_pos=0, bit index=W-1. If clear_hist=1, detector→S0; otherwise detector state is retained from the previous word. Next state SHIFT.
- SHIFT: abort=1 has priority over hold and bit consumption → IDLE, aborted=1 for one cycle, no done. match_cnt/match_pos keep partial values, detector state→S0.
- SHIFT, hold=1 (no abort): everything frozen.
- SHIFT, hold=0: consume bit[index] and step the detector.
  - If hit: match_cnt+=1 and match_pos[index]=1.
  - index==0 → DONE; otherwise index-=1.
- DONE: done=1 for exactly this one cycle, then IDLE. start is ignored in DONE and SHIFT, with no queuing.
- Latency with no hold: start accepted at edge 0, bits consumed at edges 1..W, done high in the cycle after edge W. Each hold cycle adds one cycle.
- Results hold from done until the next accepted start.
- Detector (Mealy, overlapping "101"):
  - S0: 1→S1, 0→S2
  - S1: 1→S1, 0→S3
  - S2: 1→S1, 0→S2
  - S3: 1→S1 with hit, 0→S2
  - hit is combinational from state and bit, qualified by step enable.
- match_cnt cannot overflow (max matches ≤ W).

Decomposition:
- Package seq101_pkg: controller state enum (IDLE/SHIFT/DONE), detector state enum (S0..S3), clog2 helper.
- One sub-module seq101_det with ports clk, rst, step, clear, bit_in, hit. It holds the detector state register.

Test Plan:
- W=8, word 0xAA, clear_hist=1, no hold → done in cycle 9 after start; match_cnt=3, match_pos=0x2A.
- Word 0x02 (clear_hist=1), then word 0x80 with clear_hist=0 → second word gives match_cnt=1, match_pos=0x80. Repeat the second word with clear_hist=1 → match_cnt=0, match_pos=0x00.
- Word 0xAA with hold=1 for 3 cycles after the second bit → done delayed by exactly 3 cycles; results identical to the first test.
- Word 0xAA, abort after 4 bits consumed → aborted pulse, no done, match_cnt=1, match_pos=0x20, busy=0 the next cycle.
- start held high continuously → ignored during SHIFT/DONE; next word accepted in the first IDLE cycle after done. Back-to-back words take W+2 cycles each.
- rst=0 asserted mid-SHIFT → next cycle all outputs 0, state IDLE. A following 0xAA scan with clear_hist=0 still gives match_cnt=3.

Source files
------------

// File: rtl/seq101_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq101_pkg
// Description : Shared types for the "101" scan controller. Holds the
//               controller state encoding, the detector state encoding and a
//               constant-friendly ceil(log2) helper used to size counters.
// Revision    : 1.0  initial release
// ============================================================================
package seq101_pkg;

    // Controller states. Two bits leave room for the unused fourth code,
    // which the controller treats as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_t;

    // Detector states:
    //   DET_S0 : nothing seen since the last clear
    //   DET_S1 : last bit was 1
    //   DET_S2 : last bit was 0, not preceded by a 1 worth tracking
    //   DET_S3 : last two bits were "10" (one more 1 completes a match)
    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_state_t;

    // ceil(log2(value)) for elaboration-time sizing; clog2_f(1) == 0.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq101_det.sv
`default_nettype none
// ============================================================================
// Module      : seq101_det
// Description : Overlapping "101" Mealy detector. The state register only
//               moves when step is high; clear forces the idle state and
//               wins over step.
// Ports       : clk    - clock
//               rst    - synchronous active-low reset
//               step   - consume bit_in this cycle
//               clear  - return detector to its idle state
//               bit_in - serial data bit
//               hit    - combinational: a "101" completes on this step
// Revision    : 1.0  initial release
// ============================================================================
module seq101_det
    import seq101_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic clear,
    input  logic bit_in,
    output logic hit
);

    det_state_t state;

    // Mealy output: the completing 1 arrives while the history is "10".
    assign hit = step && (state == DET_S3) && bit_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DET_S0;
        end else if (clear) begin
            state <= DET_S0;
        end else if (step) begin
            if (bit_in) begin
                // Any 1 can start (or overlap into) a new match.
                state <= DET_S1;
            end else if (state == DET_S1) begin
                state <= DET_S3;
            end else begin
                state <= DET_S2;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq101_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq101_scan_ctrl
// Description : Accepts a W-bit word on start, feeds it MSB-first through the
//               "101" detector one bit per non-held cycle, and reports the
//               match count and match positions with a one-cycle done pulse.
//               Detector history may be carried across words so a long
//               stream can be scanned in W-bit chunks.
// Ports       : clk        - clock
//               rst        - synchronous active-low reset
//               start      - scan request, honoured only in IDLE
//               word_in    - word to scan, sampled on the accepting edge
//               clear_hist - with start: clear detector history first
//               hold       - in SHIFT: consume no bit this cycle
//               abort      - in SHIFT: stop the scan, back to IDLE
//               busy       - high in SHIFT and DONE
//               done       - one-cycle pulse on normal completion
//               aborted    - one-cycle pulse after an abort
//               match_cnt  - matches found in the current/last word
//               match_pos  - bit i set if a match completed on word bit i
// Revision    : 1.0  initial release
// ============================================================================
module seq101_scan_ctrl
    import seq101_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = clog2_f(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  word_in,
    input  logic          clear_hist,
    input  logic          hold,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] match_cnt,
    output logic [W-1:0]  match_pos
);

    localparam int IW = clog2_f(W);

    ctrl_state_t   state;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;

    logic det_step;
    logic det_clear;
    logic det_bit;
    logic det_hit;

    // A bit is consumed only in SHIFT when neither abort nor hold is raised.
    assign det_step  = (state == ST_SHIFT) && !abort && !hold;
    // History is wiped on a clearing start and on every abort.
    assign det_clear = ((state == ST_IDLE)  && start && clear_hist) ||
                       ((state == ST_SHIFT) && abort);
    assign det_bit   = word[idx];

    seq101_det u_det (
        .clk    (clk),
        .rst    (rst),
        .step   (det_step),
        .clear  (det_clear),
        .bit_in (det_bit),
        .hit    (det_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            word      <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            match_cnt <= '0;
            match_pos <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word      <= word_in;
                        idx       <= IW'(W - 1);
                        match_cnt <= '0;
                        match_pos <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        // Partial results are kept for inspection.
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (!hold) begin
                        if (det_hit) begin
                            match_cnt      <= match_cnt + 1'b1;
                            match_pos[idx] <= 1'b1;
                        end
                        if (idx == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
